// File: rtl/hero_write_arb_pkg.sv
// Shared types and constants for the hero write arbiter: beat encoding, FSM states and
// default sizing.
package hero_write_arb_pkg;

    localparam int unsigned HERO_WIDTH            = 36;
    localparam int unsigned HERO_WRITE_ARB_NUM_CH = 4;
    localparam int unsigned HERO_WRITE_ARB_CH_W   = $clog2(HERO_WRITE_ARB_NUM_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        DONE  = 2'd2,
        RSVD  = 2'd3
    } CYCLE_TYPE_E;

    typedef struct packed {
        CYCLE_TYPE_E           cycle_type;
        logic [HERO_WIDTH-1:0] wdat;
    } hero_beat_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCK
    } ARB_STATE_E;

    // Only VALID and DONE beats are stored; IDLE and the reserved code are dropped.
    function automatic logic legal_beat(input logic [1:0] cycle_type);
        return (cycle_type == 2'(VALID)) || (cycle_type == 2'(DONE));
    endfunction

endpackage

// File: rtl/hero_beat_fifo.sv
// Single-clock FIFO holding packed hero beats. Depth must be a power of two so that the
// read and write pointers wrap without any extra logic.
module hero_beat_fifo #(
    parameter int unsigned Width = 38,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PtrW + 1)'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PtrW + 1)'(1);
                2'b01:   count_q <= count_q - (PtrW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/hero_write_arb.sv
// N-channel hero write arbiter: per-channel FIFOs merged round-robin onto one registered
// output, with a channel holding the bus from its first VALID beat until its DONE beat.
module hero_write_arb
    import hero_write_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = HERO_WIDTH,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CH-1:0]               in_valid,
    output logic [NUM_CH-1:0]               in_ready,
    input  logic [NUM_CH-1:0][1:0]          in_cycle_type,
    input  logic [NUM_CH-1:0][WIDTH-1:0]    in_wdat,
    output logic [1:0]                      out_cycle_type,
    output logic [WIDTH-1:0]                out_wdat,
    output logic [$clog2(NUM_CH)-1:0]       out_ch,
    input  logic                            out_ready,
    output logic [NUM_CH-1:0]               proto_err
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0]              push, pop, full, empty, legal;
    logic [NUM_CH-1:0][CNT_W-1:0]   count;
    logic [NUM_CH-1:0][WIDTH+1:0]   head;
    logic [NUM_CH-1:0]              proto_err_q;

    ARB_STATE_E        state_q, state_d;
    logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    CYCLE_TYPE_E       out_ct_q, out_ct_d;
    logic [WIDTH-1:0]  out_wdat_q, out_wdat_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;

    logic              advance;
    logic              grant_vld;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   scan_ch;
    CYCLE_TYPE_E       head_ct;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign legal[g]    = legal_beat(in_cycle_type[g]);
        assign in_ready[g] = ~rst & (count[g] < CNT_W'(DEPTH));
        assign push[g]     = in_valid[g] & in_ready[g] & legal[g] & ~full[g];

        hero_beat_fifo #(
            .Width (WIDTH + 2),
            .Depth (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[g]),
            .wdata_i ({in_cycle_type[g], in_wdat[g]}),
            .pop_i   (pop[g]),
            .rdata_o (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g]),
            .count_o (count[g])
        );
    end

    assign advance = (out_ct_q == IDLE) | out_ready;

    always_comb begin
        state_d    = state_q;
        lock_ch_d  = lock_ch_q;
        rr_ptr_d   = rr_ptr_q;
        out_ct_d   = out_ct_q;
        out_wdat_d = out_wdat_q;
        out_ch_d   = out_ch_q;
        pop        = '0;
        grant_vld  = 1'b0;
        grant      = '0;
        scan_ch    = '0;

        if (state_q == ARB_LOCK) begin
            grant_vld = ~empty[lock_ch_q];
            grant     = lock_ch_q;
        end else begin
            // Scan starts one past the last completed winner, so rr_ptr = NUM_CH-1 favours ch0.
            for (int unsigned i = 1; i <= NUM_CH; i++) begin
                scan_ch = CH_W'((32'(rr_ptr_q) + i) % NUM_CH);
                if (!grant_vld && !empty[scan_ch]) begin
                    grant_vld = 1'b1;
                    grant     = scan_ch;
                end
            end
        end

        head_ct = CYCLE_TYPE_E'(head[grant][WIDTH+1:WIDTH]);

        if (advance) begin
            if (grant_vld) begin
                pop[grant] = 1'b1;
                out_ct_d   = head_ct;
                out_wdat_d = head[grant][WIDTH-1:0];
                out_ch_d   = grant;
                if (head_ct == DONE) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = grant;
                end else begin
                    state_d   = ARB_LOCK;
                    lock_ch_d = grant;
                end
            end else begin
                // Bubble: data and channel hold, only the cycle type drops to IDLE.
                out_ct_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            lock_ch_q   <= '0;
            rr_ptr_q    <= CH_W'(NUM_CH - 1);
            out_ct_q    <= IDLE;
            out_wdat_q  <= '0;
            out_ch_q    <= '0;
            proto_err_q <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_ct_q    <= out_ct_d;
            out_wdat_q  <= out_wdat_d;
            out_ch_q    <= out_ch_d;
            proto_err_q <= in_valid & ~legal;
        end
    end

    assign out_cycle_type = out_ct_q;
    assign out_wdat       = out_wdat_q;
    assign out_ch         = out_ch_q;
    assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_hero_write_arb.sv
// Self-checking bench for hero_write_arb: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hero_write_arb;
    import hero_write_arb_pkg::*;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 36;
    localparam int DEPTH  = 4;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_ready;
    logic [NUM_CH-1:0][1:0]       in_cycle_type;
    logic [NUM_CH-1:0][WIDTH-1:0] in_wdat;
    logic [1:0]                   out_cycle_type;
    logic [WIDTH-1:0]             out_wdat;
    logic [1:0]                   out_ch;
    logic                         out_ready;
    logic [NUM_CH-1:0]            proto_err;

    always #5 clk = ~clk;

    hero_write_arb #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_cycle_type  (in_cycle_type),
        .in_wdat        (in_wdat),
        .out_cycle_type (out_cycle_type),
        .out_wdat       (out_wdat),
        .out_ch         (out_ch),
        .out_ready      (out_ready),
        .proto_err      (proto_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: per-channel queues, an owner channel while a transaction is open,
    // and the last completed winner for round-robin.
    logic [WIDTH+1:0]  mq [NUM_CH][$];
    bit                m_rdy [NUM_CH];
    int                m_owner, m_rr, m_pick, m_c, m_ch;
    logic [1:0]        m_ct;
    logic [WIDTH-1:0]  m_w;
    logic [NUM_CH-1:0] m_err;
    logic [WIDTH+1:0]  m_beat;

    always @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < NUM_CH; ch++) mq[ch].delete();
            m_owner = -1;
            m_rr    = NUM_CH - 1;
            m_ct    = 2'd0;
            m_w     = '0;
            m_ch    = 0;
            m_err   = '0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) m_rdy[ch] = (mq[ch].size() < DEPTH);
            m_err = '0;
            for (int ch = 0; ch < NUM_CH; ch++)
                if (in_valid[ch] && (in_cycle_type[ch] == 2'd0 || in_cycle_type[ch] == 2'd3))
                    m_err[ch] = 1'b1;
            if (m_ct == 2'd0 || out_ready) begin
                m_pick = -1;
                if (m_owner >= 0) begin
                    if (mq[m_owner].size() > 0) m_pick = m_owner;
                end else begin
                    for (int i = 1; i <= NUM_CH; i++) begin
                        m_c = (m_rr + i) % NUM_CH;
                        if (m_pick < 0 && mq[m_c].size() > 0) m_pick = m_c;
                    end
                end
                if (m_pick < 0) begin
                    m_ct = 2'd0;
                end else begin
                    m_beat = mq[m_pick].pop_front();
                    m_ct   = m_beat[WIDTH+1:WIDTH];
                    m_w    = m_beat[WIDTH-1:0];
                    m_ch   = m_pick;
                    if (m_ct == 2'd2) begin
                        m_owner = -1;
                        m_rr    = m_pick;
                    end else begin
                        m_owner = m_pick;
                    end
                end
            end
            for (int ch = 0; ch < NUM_CH; ch++)
                if (in_valid[ch] && m_rdy[ch] &&
                    (in_cycle_type[ch] == 2'd1 || in_cycle_type[ch] == 2'd2))
                    mq[ch].push_back({in_cycle_type[ch], in_wdat[ch]});
        end
    end

    logic [NUM_CH-1:0] m_ready_exp;
    always @(posedge clk) begin
        #2;
        for (int ch = 0; ch < NUM_CH; ch++)
            m_ready_exp[ch] = !rst && (mq[ch].size() < DEPTH);
        check("model out_cycle_type", 64'(out_cycle_type), 64'(m_ct));
        check("model out_wdat", 64'(out_wdat), 64'(m_w));
        check("model out_ch", 64'(out_ch), 64'(m_ch));
        check("model proto_err", 64'(proto_err), 64'(m_err));
        check("model in_ready", 64'(in_ready), 64'(m_ready_exp));
    end

    // Delivered-beat log: a beat leaves the output when it is non-IDLE and out_ready is high.
    int               log_ch  [$];
    int               log_ct  [$];
    int               log_cyc [$];
    logic [WIDTH-1:0] log_w   [$];

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (out_ready && out_cycle_type != 2'd0) begin
            log_ch.push_back(int'(out_ch));
            log_ct.push_back(int'(out_cycle_type));
            log_cyc.push_back(cyc);
            log_w.push_back(out_wdat);
        end
    end

    task automatic clear_log();
        log_ch.delete();
        log_ct.delete();
        log_cyc.delete();
        log_w.delete();
    endtask

    task automatic drive(input int ch, input logic [1:0] ct, input logic [WIDTH-1:0] w);
        in_valid[ch]      = 1'b1;
        in_cycle_type[ch] = ct;
        in_wdat[ch]       = w;
    endtask

    int   lock_ch_exp [4] = '{0, 0, 0, 1};
    int   lock_ct_exp [4] = '{1, 1, 2, 2};
    int   lock_w_exp  [4] = '{'h10, 'h12, 'h13, 'h11};
    int   rr_exp      [5] = '{0, 1, 2, 3, 0};
    int   k;
    logic rdy;

    initial begin
        rst = 1'b1; in_valid = '0; in_cycle_type = '0; in_wdat = '0; out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        check("reset out_cycle_type", 64'(out_cycle_type), 64'd0);
        check("reset out_wdat", 64'(out_wdat), 64'd0);
        check("reset out_ch", 64'(out_ch), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #3;
        check("in_ready after reset", 64'(in_ready), 64'hf);

        // Single beat: N+2 latency
        @(negedge clk) drive(2, 2'd2, 36'h123456789);
        @(posedge clk); #3;
        check("single not yet", 64'(out_cycle_type), 64'd0);
        @(negedge clk) in_valid = '0;
        @(posedge clk); #3;
        check("single ct", 64'(out_cycle_type), 64'd2);
        check("single wdat", 64'(out_wdat), 64'h123456789);
        check("single ch", 64'(out_ch), 64'd2);
        check("single proto_err", 64'(proto_err), 64'd0);

        // Lock: ch0 V,V,D with a competing ch1 DONE
        repeat (3) @(negedge clk);
        clear_log();
        drive(0, 2'd1, 36'h10); drive(1, 2'd2, 36'h11);
        @(negedge clk) begin in_valid = 4'b0001; drive(0, 2'd1, 36'h12); end
        @(negedge clk) drive(0, 2'd2, 36'h13);
        @(negedge clk) in_valid = '0;
        repeat (6) @(negedge clk);
        check("lock beat count", 64'(log_ch.size()), 64'd4);
        if (log_ch.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("lock ch", 64'(log_ch[i]), 64'(lock_ch_exp[i]));
                check("lock ct", 64'(log_ct[i]), 64'(lock_ct_exp[i]));
                check("lock wdat", 64'(log_w[i]), 64'(lock_w_exp[i]));
            end
            check("lock back-to-back", 64'(log_cyc[3] - log_cyc[0]), 64'd3);
        end

        // Round-robin fairness after a fresh reset
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        clear_log();
        for (int ch = 0; ch < NUM_CH; ch++) drive(ch, 2'd2, WIDTH'(32'h40 + ch));
        repeat (2) @(negedge clk);
        in_valid = '0;
        repeat (12) @(negedge clk);
        check("rr beat count", 64'(log_ch.size()), 64'd8);
        if (log_ch.size() >= 5) begin
            for (int i = 0; i < 5; i++) check("rr grant", 64'(log_ch[i]), 64'(rr_exp[i]));
            check("rr back-to-back", 64'(log_cyc[4] - log_cyc[0]), 64'd4);
        end

        // Backpressure: output holds a ch0 beat while ch3 fills its FIFO
        clear_log();
        @(negedge clk) begin out_ready = 1'b0; drive(0, 2'd2, 36'haaa); end
        @(negedge clk) in_valid = '0;
        @(negedge clk);
        check("bp held ch", 64'(out_ch), 64'd0);
        check("bp held wdat", 64'(out_wdat), 64'haaa);
        k = 0;
        for (int c = 0; c < 10; c++) begin
            if (k < 6) drive(3, 2'd2, WIDTH'(32'h300 + k)); else in_valid = '0;
            rdy = in_ready[3] && in_valid[3];
            @(posedge clk);
            if (rdy) k++;
            @(negedge clk);
        end
        check("bp accepted before full", 64'(k), 64'd4);
        check("bp in_ready[3] low", 64'(in_ready[3]), 64'd0);
        check("bp held ct", 64'(out_cycle_type), 64'd2);
        check("bp still held wdat", 64'(out_wdat), 64'haaa);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 6; c++) begin
            drive(3, 2'd2, WIDTH'(32'h300 + k));
            rdy = in_ready[3];
            @(posedge clk);
            if (rdy) k++;
            @(negedge clk);
        end
        in_valid = '0;
        check("bp all accepted", 64'(k), 64'd6);
        repeat (10) @(negedge clk);
        check("bp drain count", 64'(log_w.size()), 64'd7);
        if (log_w.size() == 7) begin
            check("bp drain first", 64'(log_w[0]), 64'haaa);
            for (int i = 0; i < 6; i++) begin
                check("bp drain order", 64'(log_w[i+1]), 64'(32'h300 + i));
                check("bp drain ch", 64'(log_ch[i+1]), 64'd3);
            end
        end

        // Protocol errors: IDLE on ch1, reserved code on ch2
        clear_log();
        @(negedge clk) begin drive(1, 2'd0, 36'h55); drive(2, 2'd3, 36'h66); end
        @(posedge clk); #3;
        check("proto_err pulse", 64'(proto_err), 64'b0110);
        @(negedge clk) in_valid = '0;
        @(posedge clk); #3;
        check("proto_err clears", 64'(proto_err), 64'd0);
        repeat (4) @(negedge clk);
        check("proto no beats", 64'(log_ch.size()), 64'd0);
        check("proto output idle", 64'(out_cycle_type), 64'd0);

        // Reset in the middle of a locked ch0 transaction
        @(negedge clk) drive(0, 2'd1, 36'h70);
        @(negedge clk) drive(0, 2'd1, 36'h71);
        @(negedge clk) in_valid = '0;
        check("mid locked ct", 64'(out_cycle_type), 64'd1);
        check("mid locked ch", 64'(out_ch), 64'd0);
        rst = 1'b1;
        @(posedge clk); #3;
        check("mid reset ct", 64'(out_cycle_type), 64'd0);
        check("mid reset in_ready", 64'(in_ready), 64'd0);
        @(negedge clk) rst = 1'b0;
        #1;
        check("mid fifos empty", 64'(in_ready), 64'hf);
        clear_log();
        @(negedge clk) drive(1, 2'd2, 36'h81);
        @(negedge clk) in_valid = '0;
        @(posedge clk); #3;
        check("post reset ct", 64'(out_cycle_type), 64'd2);
        check("post reset ch", 64'(out_ch), 64'd1);
        check("post reset wdat", 64'(out_wdat), 64'h81);
        repeat (4) @(negedge clk);
        check("post reset beats", 64'(log_ch.size()), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
